// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one request at a time, holds the fetched
// word until the decode stage consumes it, and handles redirects and misaligned targets.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic [31:0] Ins,
    output logic        en,
    output logic [31:0] pc,
    output logic        fault,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] pc_d, ins_d, count_d;
    logic        en_d, fault_d, kill_q, kill_d;
    logic        misaligned;

    assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);

    // Gating with rst keeps the request low for the whole reset window.
    assign imem_req  = (state_q == FETCH) && !rst;
    assign imem_addr = npc_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        npc_d   = npc_q;
        pc_d    = pc;
        ins_d   = Ins;
        en_d    = en;
        fault_d = fault;
        count_d = instr_count;
        kill_d  = kill_q;

        if (misaligned && state_q != HALT) begin
            fault_d = 1'b1;
            en_d    = 1'b0;
            ins_d   = NOP_INS;
            kill_d  = 1'b0;
            state_d = HALT;
        end else begin
            case (state_q)
                FETCH: begin
                    if (branch_taken) npc_d = branch_target;
                    if (imem_gnt) begin
                        kill_d  = branch_taken;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q || branch_taken) begin
                            // Response belongs to a squashed path: drop it.
                            if (branch_taken) npc_d = branch_target;
                            kill_d  = 1'b0;
                            state_d = FETCH;
                        end else begin
                            ins_d   = imem_rdata;
                            pc_d    = npc_q;
                            en_d    = 1'b1;
                            npc_d   = npc_q + 32'd4;
                            state_d = HOLD;
                        end
                    end else if (branch_taken) begin
                        npc_d  = branch_target;
                        kill_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        npc_d   = branch_target;
                        en_d    = 1'b0;
                        ins_d   = NOP_INS;
                        state_d = FETCH;
                    end else if (en && id_ready) begin
                        en_d    = 1'b0;
                        ins_d   = NOP_INS;
                        count_d = instr_count + 32'd1;
                        state_d = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            npc_q       <= RESET_PC;
            pc          <= RESET_PC;
            Ins         <= NOP_INS;
            en          <= 1'b0;
            fault       <= 1'b0;
            instr_count <= 32'd0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            npc_q       <= npc_d;
            pc          <= pc_d;
            Ins         <= ins_d;
            en          <= en_d;
            fault       <= fault_d;
            instr_count <= count_d;
            kill_q      <= kill_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a per-cycle vector table for the redirect and
// fault corners, a scoreboarded random fetch stream, reset-in-flight and counter wrap.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid, branch_taken, id_ready;
    logic [31:0] imem_addr, imem_rdata, branch_target;
    logic [31:0] ins, pc, instr_count;
    logic        en, fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .id_ready(id_ready), .Ins(ins), .en(en), .pc(pc),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt, rv, br, idr;
        logic [31:0] rdata, tgt;
        logic        req, en, flt;
        logic [31:0] addr, ins, pc, cnt;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } sb_t;

    vec_t tbl[28];
    sb_t  sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                          input logic br, input logic [31:0] tg, input logic idr);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        branch_taken = br; branch_target = tg; id_ready = idr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic br, logic [31:0] tg,
                                logic idr, logic req, logic [31:0] addr, logic e,
                                logic [31:0] i, logic [31:0] p, logic f, logic [31:0] c);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.br = br; v.tgt = tg; v.idr = idr;
        v.req = req; v.addr = addr; v.en = e; v.ins = i; v.pc = p; v.flt = f; v.cnt = c;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_en"},    {31'd0, en},       32'd0);
        check({tag, "_fault"}, {31'd0, fault},    32'd0);
        check({tag, "_addr"},  imem_addr,         32'd0);
        check({tag, "_ins"},   ins,               NOP);
        check({tag, "_pc"},    pc,                32'd0);
        check({tag, "_cnt"},   instr_count,       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr, exp_cnt, rd;
        sb_t         item;

        // Cycle-by-cycle table: inputs in the cycle, outputs expected in the same cycle.
        tbl[0]  = mk(1,0,32'h0,       0,32'h0,  0, 1,32'h0,  0,NOP,         32'h0,  0,0);
        tbl[1]  = mk(0,1,32'h00500093,0,32'h0,  1, 0,32'h0,  0,NOP,         32'h0,  0,0);
        tbl[2]  = mk(0,0,32'h0,       0,32'h0,  1, 0,32'h4,  1,32'h00500093,32'h0,  0,0);
        tbl[3]  = mk(1,0,32'h0,       0,32'h0,  0, 1,32'h4,  0,NOP,         32'h0,  0,1);
        tbl[4]  = mk(0,1,32'h00A00113,0,32'h0,  0, 0,32'h4,  0,NOP,         32'h0,  0,1);
        for (int i = 5; i <= 9; i++)
            tbl[i] = mk(0,0,32'h0,    0,32'h0,  0, 0,32'h8,  1,32'h00A00113,32'h4,  0,1);
        tbl[10] = mk(0,0,32'h0,       0,32'h0,  1, 0,32'h8,  1,32'h00A00113,32'h4,  0,1);
        tbl[11] = mk(0,0,32'h0,       1,32'h200,0, 1,32'h8,  0,NOP,         32'h4,  0,2);
        tbl[12] = mk(1,0,32'h0,       0,32'h0,  0, 1,32'h200,0,NOP,         32'h4,  0,2);
        tbl[13] = mk(0,0,32'h0,       1,32'h100,0, 0,32'h200,0,NOP,         32'h4,  0,2);
        tbl[14] = mk(0,1,32'hDEADBEEF,0,32'h0,  0, 0,32'h100,0,NOP,         32'h4,  0,2);
        tbl[15] = mk(1,0,32'h0,       1,32'h300,0, 1,32'h100,0,NOP,         32'h4,  0,2);
        tbl[16] = mk(0,1,32'hBADBAD00,0,32'h0,  0, 0,32'h300,0,NOP,         32'h4,  0,2);
        tbl[17] = mk(1,0,32'h0,       0,32'h0,  0, 1,32'h300,0,NOP,         32'h4,  0,2);
        tbl[18] = mk(0,1,32'h0BADF00D,1,32'h400,0, 0,32'h300,0,NOP,         32'h4,  0,2);
        tbl[19] = mk(1,0,32'h0,       0,32'h0,  0, 1,32'h400,0,NOP,         32'h4,  0,2);
        tbl[20] = mk(0,1,32'h11111111,0,32'h0,  0, 0,32'h400,0,NOP,         32'h4,  0,2);
        tbl[21] = mk(0,0,32'h0,       1,32'h500,1, 0,32'h404,1,32'h11111111,32'h400,0,2);
        tbl[22] = mk(0,1,32'h22222222,0,32'h0,  1, 1,32'h500,0,NOP,         32'h400,0,2);
        tbl[23] = mk(1,0,32'h0,       0,32'h0,  0, 1,32'h500,0,NOP,         32'h400,0,2);
        tbl[24] = mk(0,0,32'h0,       1,32'h102,0, 0,32'h500,0,NOP,         32'h400,0,2);
        tbl[25] = mk(0,1,32'h33333333,0,32'h0,  1, 0,32'h500,0,NOP,         32'h400,1,2);
        tbl[26] = mk(1,0,32'h0,       0,32'h0,  1, 0,32'h500,0,NOP,         32'h400,1,2);
        tbl[27] = mk(1,0,32'h0,       1,32'h200,1, 0,32'h500,0,NOP,         32'h400,1,2);

        rst = 1'b1;
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        repeat (3) next_cycle();
        @(negedge clk);
        check_reset_state("reset");
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            set_in(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].br, tbl[i].tgt, tbl[i].idr);
            @(negedge clk);
            check($sformatf("v%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].req});
            check($sformatf("v%0d_addr", i),  imem_addr,         tbl[i].addr);
            check($sformatf("v%0d_en", i),    {31'd0, en},       {31'd0, tbl[i].en});
            check($sformatf("v%0d_ins", i),   ins,               tbl[i].ins);
            check($sformatf("v%0d_pc", i),    pc,                tbl[i].pc);
            check($sformatf("v%0d_fault", i), {31'd0, fault},    {31'd0, tbl[i].flt});
            check($sformatf("v%0d_cnt", i),   instr_count,       tbl[i].cnt);
            next_cycle();
        end

        // Reset clears the halt; then reset again while a request is outstanding.
        rst = 1'b1;
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check_reset_state("halt_reset");
        next_cycle();
        rst = 1'b0;
        set_in(1, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check("rw_fetch_req", {31'd0, imem_req}, 32'd1);
        next_cycle();
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check("rw_wait_req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rw_mid");
        next_cycle();
        rst = 1'b0;
        set_in(0, 1, 32'hFEEDFACE, 0, 32'h0, 1);
        @(negedge clk);
        check("rw_late_req",  {31'd0, imem_req}, 32'd1);
        check("rw_late_addr", imem_addr,         32'd0);
        check("rw_late_en",   {31'd0, en},       32'd0);
        next_cycle();
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check("rw_after_en",  {31'd0, en},       32'd0);
        check("rw_after_req", {31'd0, imem_req}, 32'd1);
        check("rw_after_ins", ins,               NOP);
        next_cycle();

        // Random-timing fetch stream; delivered words are scoreboarded.
        exp_addr = 32'h0;
        exp_cnt  = 32'h0;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 2)) begin
                set_in(0, 0, 32'h0, 0, 32'h0, 0);
                @(negedge clk);
                check("st_stall_req",  {31'd0, imem_req}, 32'd1);
                check("st_stall_addr", imem_addr,         exp_addr);
                next_cycle();
            end
            set_in(1, 0, 32'h0, 0, 32'h0, 0);
            @(negedge clk);
            check("st_gnt_addr", imem_addr, exp_addr);
            next_cycle();
            repeat ($urandom_range(0, 2)) begin
                set_in(0, 0, 32'h0, 0, 32'h0, 0);
                @(negedge clk);
                check("st_wait_req", {31'd0, imem_req}, 32'd0);
                next_cycle();
            end
            rd = $urandom;
            set_in(0, 1, rd, 0, 32'h0, 0);
            sb.push_back('{ins: rd, pc: exp_addr});
            @(negedge clk);
            check("st_rv_en", {31'd0, en}, 32'd0);
            next_cycle();
            repeat ($urandom_range(0, 3)) begin
                set_in(0, 0, 32'h0, 0, 32'h0, 0);
                @(negedge clk);
                check("st_hold_en",  {31'd0, en},       32'd1);
                check("st_hold_req", {31'd0, imem_req}, 32'd0);
                next_cycle();
            end
            set_in(0, 0, 32'h0, 0, 32'h0, 1);
            @(negedge clk);
            check("st_deliver_en", {31'd0, en}, 32'd1);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                check("st_ins", ins, item.ins);
                check("st_pc",  pc,  item.pc);
            end else begin
                check("st_sb_empty", 32'd0, 32'd1);
            end
            check("st_cnt_before", instr_count, exp_cnt);
            next_cycle();
            exp_addr = exp_addr + 32'd4;
            exp_cnt  = exp_cnt + 32'd1;
        end
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check("st_cnt_final", instr_count, exp_cnt);
        check("st_next_addr", imem_addr,   exp_addr);

        // Counter wrap: preload all-ones while an instruction is held, then deliver it.
        set_in(1, 0, 32'h0, 0, 32'h0, 0);
        next_cycle();
        set_in(0, 1, 32'h00000013, 0, 32'h0, 0);
        next_cycle();
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        force dut.instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count;
        next_cycle();
        @(negedge clk);
        check("wrap_pre", instr_count, 32'hFFFF_FFFF);
        check("wrap_en",  {31'd0, en}, 32'd1);
        next_cycle();
        set_in(0, 0, 32'h0, 0, 32'h0, 1);
        next_cycle();
        set_in(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        check("wrap_post", instr_count, 32'd0);
        check("wrap_en0",  {31'd0, en}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
